// File: rtl/settings_menu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : settings_menu_pkg
//  Description : Shared types and constants for the settings menu sequencer:
//                FSM state encoding, setting-field encoding (matches the bit
//                order of the field_en bus), field count, default timing
//                parameters and the one-hot field enable helper.
//  Revision    : 1.0  initial release
// ============================================================================
package settings_menu_pkg;

  localparam int FIELD_COUNT = 8;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 100_000_000;
  localparam int unsigned COMMIT_DELAY_DEFAULT   = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_EDIT   = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

  // Field index == bit position in field_en.
  typedef enum logic [2:0] {
    F_NUM_3   = 3'd0,
    F_NUM_2   = 3'd1,
    F_NUM_1   = 3'd2,
    F_RING_2  = 3'd3,
    F_RING_1  = 3'd4,
    F_START_3 = 3'd5,
    F_START_2 = 3'd6,
    F_START_1 = 3'd7
  } field_e;

  function automatic logic [FIELD_COUNT-1:0] field_onehot(input logic [2:0] sel);
    return {{(FIELD_COUNT-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/settings_menu_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge
//  Description : Rising-edge detector for one debounced button level. The
//                previous-sample register resets to 1 so that a button held
//                through reset does not produce an event on release.
//  Ports       : i_clock  system clock
//                reset    synchronous active-high reset
//                i_level  debounced, synchronized button level
//                o_rise   high while i_level=1 and the previous sample was 0
//  Revision    : 1.0  initial release
// ============================================================================
module btn_edge (
  input  logic i_clock,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_level;
  end

  always_ff @(posedge i_clock) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Combinational so the event acts on the same edge that samples it.
  assign o_rise = i_level & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/settings_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : settings_menu_ctrl
//  Description : Front-panel sequencer sharing the rotary encoder across the
//                eight Enigma setting fields. RUN -> EDIT on a next event
//                (when the cipher is idle), next/back walk the fields, run
//                leaves through COMMIT, which drops all enables, waits
//                COMMIT_DELAY cycles and emits a one-cycle commit pulse.
//  Config      : SETTINGS_IDLE_TIMEOUT_EN - when defined, an idle counter in
//                EDIT forces the COMMIT exit after TIMEOUT_CYCLES idle cycles
//                and pulses timed_out; otherwise timed_out is tied low.
//  Ports       : i_clock    system clock
//                reset      synchronous active-high reset
//                btn_next   next-field button level
//                btn_back   previous-field button level
//                btn_run    leave-edit button level
//                rotary_a/b encoder phases (activity indication only)
//                enc_busy   cipher mid-character, blocks EDIT entry
//                field_en   one-hot edit enables (registered)
//                field_sel  active field index (registered)
//                edit_mode  high in EDIT (registered)
//                commit     one-cycle pulse at the end of COMMIT
//                timed_out  one-cycle pulse on an idle-timeout exit
//  Revision    : 1.0  initial release
// ============================================================================
module settings_menu_ctrl
  import settings_menu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned COMMIT_DELAY   = COMMIT_DELAY_DEFAULT
) (
  input  logic                   i_clock,
  input  logic                   reset,
  input  logic                   btn_next,
  input  logic                   btn_back,
  input  logic                   btn_run,
  input  logic                   rotary_a,
  input  logic                   rotary_b,
  input  logic                   enc_busy,
  output logic [FIELD_COUNT-1:0] field_en,
  output logic [2:0]             field_sel,
  output logic                   edit_mode,
  output logic                   commit,
  output logic                   timed_out
);

  // --------------------------------------------------------------------------
  // Button edge detection: bit 0 next, bit 1 back, bit 2 run
  // --------------------------------------------------------------------------
  logic [2:0] w_levels;
  logic [2:0] w_rise;
  logic       w_next_ev;
  logic       w_back_ev;
  logic       w_run_ev;

  assign w_levels = {btn_run, btn_back, btn_next};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_edge u_btn_edge (
      .i_clock (i_clock),
      .reset   (reset),
      .i_level (w_levels[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  assign w_next_ev = w_rise[0];
  assign w_back_ev = w_rise[1];
  assign w_run_ev  = w_rise[2];

  // --------------------------------------------------------------------------
  // Main state registers
  // --------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [2:0]             field_sel_q, field_sel_d;
  logic [FIELD_COUNT-1:0] field_en_q, field_en_d;
  logic                   edit_mode_q, edit_mode_d;
  logic                   commit_q, commit_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   w_timeout;

  // --------------------------------------------------------------------------
  // Optional idle timeout
  // --------------------------------------------------------------------------
`ifdef SETTINGS_IDLE_TIMEOUT_EN
  localparam logic [26:0] IDLE_LAST = 27'(TIMEOUT_CYCLES - 1);

  logic [26:0] idle_q, idle_d;
  logic [1:0]  rot_q, rot_d;
  logic        timed_out_q, timed_out_d;
  logic        w_activity;

  assign w_activity = w_next_ev | w_back_ev | w_run_ev |
                      (|({rotary_a, rotary_b} ^ rot_q));

  // Timeout only fires on a quiet cycle, so a run event always wins.
  assign w_timeout = (state_q == ST_EDIT) && !w_activity && (idle_q == IDLE_LAST);

  always_comb begin
    rot_d       = {rotary_a, rotary_b};
    timed_out_d = w_timeout;
    idle_d      = '0;
    if ((state_q == ST_EDIT) && !w_activity && !w_timeout) begin
      idle_d = idle_q + 27'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (reset) begin
      idle_q      <= '0;
      rot_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      rot_q       <= rot_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timed_out = timed_out_q;
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign timed_out    = 1'b0;
  assign w_unused_cfg = ^{rotary_a, rotary_b, 1'(TIMEOUT_CYCLES)};
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. Outputs are computed from the next state so they are
  // registered yet reflect an event on the very edge that samples it.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    field_sel_d = field_sel_q;
    cnt_d       = cnt_q;
    commit_d    = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A next event while the cipher is busy is simply lost.
        if (w_next_ev && !enc_busy) begin
          state_d     = ST_EDIT;
          field_sel_d = 3'd0;
        end
      end

      ST_EDIT: begin
        if (w_run_ev || w_timeout) begin
          state_d = ST_COMMIT;
          cnt_d   = 4'(COMMIT_DELAY);
        end else if (w_next_ev && !w_back_ev) begin
          field_sel_d = field_sel_q + 3'd1;
        end else if (w_back_ev && !w_next_ev) begin
          field_sel_d = field_sel_q - 3'd1;
        end
      end

      ST_COMMIT: begin
        // Pulse is registered as the counter lands on 0; RUN follows a cycle later.
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          commit_d = (cnt_q == 4'd1);
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    edit_mode_d = (state_d == ST_EDIT);
    field_en_d  = edit_mode_d ? field_onehot(field_sel_d) : '0;
  end

  always_ff @(posedge i_clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      field_sel_q <= 3'd0;
      field_en_q  <= '0;
      edit_mode_q <= 1'b0;
      commit_q    <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      field_sel_q <= field_sel_d;
      field_en_q  <= field_en_d;
      edit_mode_q <= edit_mode_d;
      commit_q    <= commit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign field_en  = field_en_q;
  assign field_sel = field_sel_q;
  assign edit_mode = edit_mode_q;
  assign commit    = commit_q;

endmodule
`default_nettype wire

// File: tb/tb_settings_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_settings_menu_ctrl
//  Description : Self-checking bench for settings_menu_ctrl: a directed vector
//                table, hand-written multi-cycle sequences and randomized
//                stimulus checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_settings_menu_ctrl;

  localparam int T_OUT = 20;
  localparam int C_DLY = 2;
`ifdef SETTINGS_IDLE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       i_clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0, btn_back = 1'b0, btn_run = 1'b0;
  logic       rotary_a = 1'b0, rotary_b = 1'b0, enc_busy = 1'b0;
  logic [7:0] field_en;
  logic [2:0] field_sel;
  logic       edit_mode, commit, timed_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clock = ~i_clock;

  settings_menu_ctrl #(.TIMEOUT_CYCLES(T_OUT), .COMMIT_DELAY(C_DLY)) dut (
    .i_clock   (i_clock),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_back  (btn_back),
    .btn_run   (btn_run),
    .rotary_a  (rotary_a),
    .rotary_b  (rotary_b),
    .enc_busy  (enc_busy),
    .field_en  (field_en),
    .field_sel (field_sel),
    .edit_mode (edit_mode),
    .commit    (commit),
    .timed_out (timed_out)
  );

  // --------------------------------------------------------------------------
  // Behavioural model: mode 0 run / 1 edit / 2 commit, edge-numbered timing
  // --------------------------------------------------------------------------
  int m_mode = 0, m_sel = 0, m_edge = 0, m_last_act = 0, m_commit_edge = 0;
  bit m_commit = 0, m_timed = 0;
  bit m_pn = 1, m_pb = 1, m_pr = 1, m_pa = 0, m_prb = 0;

  task automatic model_edge();
    bit en, eb, er, act;
    m_edge++;
    m_commit = 0;
    m_timed  = 0;
    if (reset) begin
      m_mode = 0; m_sel = 0;
      m_pn = 1; m_pb = 1; m_pr = 1; m_pa = 0; m_prb = 0;
      return;
    end
    en  = btn_next && !m_pn;
    eb  = btn_back && !m_pb;
    er  = btn_run && !m_pr;
    act = en || eb || er || (rotary_a != m_pa) || (rotary_b != m_prb);
    case (m_mode)
      0: if (en && !enc_busy) begin
        m_mode = 1; m_sel = 0; m_last_act = m_edge;
      end
      1: if (er) begin
        m_mode = 2; m_commit_edge = m_edge + C_DLY;
      end else if (TO_EN && !act && (m_edge - m_last_act == T_OUT)) begin
        m_mode = 2; m_timed = 1; m_commit_edge = m_edge + C_DLY;
      end else begin
        if (act) m_last_act = m_edge;
        if (en && !eb) m_sel = (m_sel + 1) % 8;
        else if (eb && !en) m_sel = (m_sel + 7) % 8;
      end
      default: begin
        if (m_edge == m_commit_edge) m_commit = 1;
        else if (m_edge == m_commit_edge + 1) m_mode = 0;
      end
    endcase
    m_pn = btn_next; m_pb = btn_back; m_pr = btn_run;
    m_pa = rotary_a; m_prb = rotary_b;
  endtask

  // One active edge: inputs are stable here, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge i_clock);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input bit e_edit, input int e_sel,
                       input logic [7:0] e_en, input bit e_commit, input bit e_to);
    n_vec++;
    if (edit_mode !== e_edit || field_sel !== 3'(e_sel) || field_en !== e_en ||
        commit !== e_commit || timed_out !== e_to || $countones(field_en) > 1) begin
      n_bad++;
      $display("FAIL %s @%0t: got edit=%b sel=%0d en=%h commit=%b to=%b, want edit=%b sel=%0d en=%h commit=%b to=%b",
               name, $time, edit_mode, field_sel, field_en, commit, timed_out,
               e_edit, e_sel, e_en, e_commit, e_to);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_mode == 1, m_sel, (m_mode == 1) ? 8'(1 << m_sel) : 8'h00,
          m_commit, m_timed);
  endtask

  task automatic drive(input bit r, input bit n, input bit b, input bit rn, input bit bz);
    reset = r; btn_next = n; btn_back = b; btn_run = rn; enc_busy = bz;
  endtask

  // Reset, release, and enter EDIT at field 0.
  task automatic enter_edit();
    drive(1, 0, 0, 0, 0); rotary_a = 0; rotary_b = 0; tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    check("enter_edit", 1, 0, 8'h01, 0, 0);
  endtask

  typedef struct {
    bit         rst, nx, bk, rn, busy;
    bit         e_edit;
    int         e_sel;
    logic [7:0] e_en;
    bit         e_commit;
  } vec_t;

  vec_t tbl[33];

  initial begin
    // rst nx bk rn busy | edit sel en commit
    tbl[0]  = '{1,0,0,0,0, 0,0,8'h00,0};   // reset state
    tbl[1]  = '{0,0,0,0,0, 0,0,8'h00,0};
    tbl[2]  = '{0,1,0,0,0, 1,0,8'h01,0};   // enter EDIT
    tbl[3]  = '{0,0,0,0,0, 1,0,8'h01,0};
    tbl[4]  = '{0,1,0,0,0, 1,1,8'h02,0};
    tbl[5]  = '{0,0,0,0,0, 1,1,8'h02,0};
    tbl[6]  = '{0,0,1,0,0, 1,0,8'h01,0};
    tbl[7]  = '{0,0,0,0,0, 1,0,8'h01,0};
    tbl[8]  = '{0,0,1,0,0, 1,7,8'h80,0};   // back wraps 0 -> 7
    tbl[9]  = '{0,0,0,0,0, 1,7,8'h80,0};
    tbl[10] = '{0,1,0,0,0, 1,0,8'h01,0};   // next wraps 7 -> 0
    tbl[11] = '{0,0,0,0,0, 1,0,8'h01,0};
    tbl[12] = '{0,1,1,0,0, 1,0,8'h01,0};   // next+back together ignored
    tbl[13] = '{0,0,0,0,0, 1,0,8'h01,0};
    tbl[14] = '{0,1,0,1,0, 0,0,8'h00,0};   // run beats next, COMMIT at k
    tbl[15] = '{0,0,0,0,0, 0,0,8'h00,0};   // k+1
    tbl[16] = '{0,0,0,0,0, 0,0,8'h00,1};   // commit after k+2
    tbl[17] = '{0,0,0,0,0, 0,0,8'h00,0};   // RUN at k+3
    tbl[18] = '{0,1,0,0,1, 0,0,8'h00,0};   // busy drops the next event
    tbl[19] = '{0,0,0,0,0, 0,0,8'h00,0};
    tbl[20] = '{0,1,0,0,0, 1,0,8'h01,0};
    tbl[21] = '{0,0,0,0,0, 1,0,8'h01,0};
    tbl[22] = '{0,1,0,0,0, 1,1,8'h02,0};
    tbl[23] = '{0,0,0,0,0, 1,1,8'h02,0};
    tbl[24] = '{0,0,0,1,0, 0,1,8'h00,0};   // COMMIT, field_sel held
    tbl[25] = '{0,0,0,0,0, 0,1,8'h00,0};
    tbl[26] = '{1,0,0,0,0, 0,0,8'h00,0};   // reset on the would-be commit edge
    tbl[27] = '{0,0,0,0,0, 0,0,8'h00,0};
    tbl[28] = '{1,1,0,0,0, 0,0,8'h00,0};   // next held through reset
    tbl[29] = '{0,1,0,0,0, 0,0,8'h00,0};
    tbl[30] = '{0,1,0,0,0, 0,0,8'h00,0};
    tbl[31] = '{0,0,0,0,0, 0,0,8'h00,0};
    tbl[32] = '{0,1,0,0,0, 1,0,8'h01,0};   // fresh rise enters EDIT

    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].rst, tbl[i].nx, tbl[i].bk, tbl[i].rn, tbl[i].busy);
      tick();
      check($sformatf("table[%0d]", i), tbl[i].e_edit, tbl[i].e_sel,
            tbl[i].e_en, tbl[i].e_commit, 1'b0);
    end

    // Eight next pulses walk 1..7 and wrap to 0.
    enter_edit();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 0, 0, 0); tick();
      check($sformatf("walk_rise%0d", i), 1, i % 8, 8'(1 << (i % 8)), 0, 0);
      drive(0, 0, 0, 0, 0); tick();
      check($sformatf("walk_low%0d", i), 1, i % 8, 8'(1 << (i % 8)), 0, 0);
    end

`ifdef SETTINGS_IDLE_TIMEOUT_EN
    // Regular encoder activity keeps EDIT alive.
    enter_edit();
    for (int t = 0; t < 6; t++) begin
      rotary_a = ~rotary_a; tick();
      check("to_toggle", 1, 0, 8'h01, 0, 0);
      for (int j = 1; j < 10; j++) begin
        tick();
        check("to_active", 1, 0, 8'h01, 0, 0);
      end
    end
    // Last toggle, then silence: timeout exactly T_OUT edges later.
    rotary_a = ~rotary_a; tick();
    for (int j = 1; j < T_OUT; j++) begin
      tick();
      check("to_wait", 1, 0, 8'h01, 0, 0);
    end
    tick(); check("to_fire", 0, 0, 8'h00, 0, 1);
    tick(); check("to_k1", 0, 0, 8'h00, 0, 0);
    tick(); check("to_commit", 0, 0, 8'h00, 1, 0);
    tick(); check("to_done", 0, 0, 8'h00, 0, 0);
`else
    // Without the timeout feature EDIT persists indefinitely.
    enter_edit();
    for (int j = 0; j < 3 * T_OUT; j++) begin
      tick();
      check("no_timeout", 1, 0, 8'h01, 0, 0);
    end
`endif

    // Randomized stimulus against the model.
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(299) == 0);
      if ($urandom_range(15) == 0) btn_next = ~btn_next;
      if ($urandom_range(15) == 0) btn_back = ~btn_back;
      if ($urandom_range(23) == 0) btn_run  = ~btn_run;
      if ($urandom_range(3)  == 0) enc_busy = ~enc_busy;
      if ($urandom_range(39) == 0) rotary_a = ~rotary_a;
      if ($urandom_range(39) == 0) rotary_b = ~rotary_b;
      tick();
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/settings_menu_ctrl.md
# settings_menu_ctrl

Front-panel sequencer that shares the single rotary encoder among the eight Enigma setting fields (rotor number ×3, ring ×2, start position ×3). It walks the operator through the fields with next/back buttons, drives exactly one field-edit enable into `rotor_settings`, and on exit runs a commit sequence: enables drop, the settings registers settle, and a one-cycle `commit` pulse is issued to the cipher datapath. It sits between the debounced button synchronizers and `rotor_settings`.

## Interface
- `TIMEOUT_CYCLES`, default 100_000_000: idle cycles in EDIT before an automatic exit.
- `COMMIT_DELAY`, default 2: cycles with all enables low before `commit` fires; legal range 1..15.
- `i_clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `btn_next`  in  1  debounced, synchronized level.
- `btn_back`  in  1  debounced, synchronized level.
- `btn_run`  in  1  debounced, synchronized level.
- `rotary_a`, `rotary_b`  in  1 each  encoder phases; used only as activity indication.
- `enc_busy`  in  1  cipher datapath mid-character; blocks entry to EDIT.
- `field_en`  out  8  one-hot edit enables. Bit mapping: [0] num_3, [1] num_2, [2] num_1, [3] ring_2, [4] ring_1, [5] start_3, [6] start_2, [7] start_1.
- `field_sel`  out  3  index of the active field.
- `edit_mode`  out  1  high in EDIT.
- `commit`  out  1  one-cycle pulse at the end of COMMIT.
- `timed_out`  out  1  one-cycle pulse when an idle timeout forces the exit.

## Operation
- States: RUN, EDIT, COMMIT.
- Button events are rising edges: a level that is high now and was low at the previous sample. The previous-sample registers reset to 1, so a button held through reset produces no event.
- RUN:
  - `btn_next` event with `enc_busy`=0 → EDIT with `field_sel`=0.
  - A `btn_next` event while `enc_busy`=1 is dropped, not queued.
  - All other events are ignored.
- EDIT:
  - `field_en` = one-hot(`field_sel`).
  - `btn_next` event advances the field: 7→0 wraps.
  - `btn_back` event moves back a field: 0→7 wraps.
  - Next and back events in the same cycle: both ignored.
  - `btn_run` event → COMMIT. It has priority over next/back in the same cycle.
  - `enc_busy` is ignored in EDIT.
- COMMIT:
  - `field_en`=0 and `field_sel` holds its value.
  - A down-counter loads `COMMIT_DELAY` on entry.
  - When the count reaches 0, `commit`=1 for that one cycle and the state moves to RUN.
  - All button events are ignored.
- Reset, including mid-EDIT or mid-COMMIT, gives: state RUN, `field_sel`=0, `field_en`=0, `edit_mode`=0, `commit`=0, `timed_out`=0, counters 0. No commit is issued.

## Timing
- All outputs are registers.
- An event sampled at edge k updates `field_sel`, `field_en` and `edit_mode` at edge k. They are visible for the cycle after edge k.
- COMMIT entered at edge k:
  - `field_en` is low from edge k.
  - `commit` is high in the cycle after edge k+`COMMIT_DELAY`.
  - RUN is reached at edge k+`COMMIT_DELAY`+1.
  - With the default of 2, `rotor_settings` has two full cycles to register its final values before `commit`.
- `commit` and `timed_out` are never high for more than one cycle.
- A switch between fields in EDIT is break-free: the old enable bit falls and the new one rises on the same edge. No cycle ever has two enable bits high.

## Configuration
- `SETTINGS_IDLE_TIMEOUT_EN` defined:
  - In EDIT, a 27-bit idle counter increments every cycle.
  - It clears on any button event or on any change of `rotary_a`/`rotary_b` versus their previous samples.
  - When it reaches `TIMEOUT_CYCLES`-1 → COMMIT, with `timed_out` pulsed on that same edge.
  - A `btn_run` event in the same cycle takes precedence, and `timed_out` stays 0.
- `SETTINGS_IDLE_TIMEOUT_EN` undefined:
  - No counter is built.
  - `timed_out` is tied to 0.
  - EDIT exits only on a `btn_run` event.

## Structure
- Shared package `settings_menu_pkg` holds:
  - state enum RUN/EDIT/COMMIT;
  - field enum with the bit mapping above;
  - `FIELD_COUNT`=8;
  - default values for `TIMEOUT_CYCLES` and `COMMIT_DELAY`.
- One sub-module, `btn_edge`: a previous-sample register plus a rising-edge detector. It is instantiated three times, once per button.

## Test plan
- Reset, release, then `btn_next` pulse with `enc_busy`=0 → `edit_mode`=1, `field_en`=8'h01 one cycle later. Repeat the same pulse with `enc_busy`=1 → stays in RUN, `field_en`=0.
- In EDIT, 8 `btn_next` pulses → `field_sel` goes 1..7 then 0. One `btn_back` from 0 → `field_sel`=7, `field_en`=8'h80. Check every cycle that `field_en` is never two-hot.
- `btn_run` pulse at edge k with `COMMIT_DELAY`=2 → `field_en`=0 after k, `commit` high only in the cycle after k+2, `edit_mode`=0.
- Simultaneous next and back → `field_sel` unchanged. Simultaneous run and next → COMMIT entered, `field_sel` unchanged.
- Assert `reset` mid-COMMIT → no `commit` pulse, all outputs 0. Hold `btn_next` high through reset release → no EDIT entry until it falls and rises again.
- With `SETTINGS_IDLE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20:
  - Toggle `rotary_a` every 10 cycles → no timeout.
  - Stop toggling → `timed_out` and COMMIT entry exactly 20 cycles after the last toggle, followed by `commit`.
